// File: rtl/y86_seq_ctrl_pkg.sv
// Shared definitions for the Y86 SEQ stage sequencer.
// Optional single-step mode is controlled by the Y86_SINGLE_STEP_EN macro.
package y86_seq_ctrl_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    // Processor status
    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    // Sequencer states
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PCUPDATE  = 3'd5,
`ifdef Y86_SINGLE_STEP_EN
        S_STOP      = 3'd6,
        S_STEPWAIT  = 3'd7
`else
        S_STOP      = 3'd6
`endif
    } state_t;

    // Stage enable bit positions
    localparam int unsigned STAGE_W   = 6;
    localparam int unsigned STG_FETCH = 0;
    localparam int unsigned STG_DEC   = 1;
    localparam int unsigned STG_EX    = 2;
    localparam int unsigned STG_MEM   = 3;
    localparam int unsigned STG_WB    = 4;
    localparam int unsigned STG_PCUPD = 5;

    // Instructions that touch data memory
    function automatic logic needs_mem(input logic [3:0] icode);
        return (icode == I_RMMOVL) || (icode == I_MRMOVL) || (icode == I_CALL) ||
               (icode == I_RET)    || (icode == I_PUSHL)  || (icode == I_POPL);
    endfunction

    // Instructions that write the register file without a memory access
    function automatic logic needs_wb_only(input logic [3:0] icode);
        return (icode == I_RRMOVL) || (icode == I_IRMOVL) || (icode == I_OPL);
    endfunction

endpackage

// File: rtl/y86_pc_sel.sv
// Combinational next-PC selection for the PCUPDATE stage.
module y86_pc_sel
    import y86_seq_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic [3:0]      icode,
    input  logic            cnd,
    input  logic [PC_W-1:0] valp,
    input  logic [PC_W-1:0] valc,
    input  logic [PC_W-1:0] valm,
    output logic [PC_W-1:0] next_pc
);

    // Taken jump and call go to the constant, ret to the popped address
    always_comb begin
        next_pc = valp;
        if ((icode == I_JXX && cnd) || icode == I_CALL) begin
            next_pc = valc;
        end else if (icode == I_RET) begin
            next_pc = valm;
        end
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86 SEQ core; owns PC and status.
// Define Y86_SINGLE_STEP_EN to hold each new fetch until a step_i pulse.
module y86_seq_ctrl
    import y86_seq_ctrl_pkg::*;
#(
    parameter int unsigned    PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         icode_i,
    input  logic               cnd_i,
    input  logic [PC_W-1:0]    valP_i,
    input  logic [PC_W-1:0]    valC_i,
    input  logic [PC_W-1:0]    valM_i,
    input  logic               mem_ack_i,
    input  logic               mem_err_i,
    input  logic               step_i,
    output logic               mem_req_o,
    output logic               mem_ifetch_o,
    output logic [STAGE_W-1:0] stage_en_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [1:0]         stat_o,
    output logic               halted_o
);

    state_t          state, state_nxt;
    stat_t           stat, stat_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_sel;
    logic            run;

`ifndef Y86_SINGLE_STEP_EN
    logic step_unused;
    assign step_unused = step_i;
`endif

    y86_pc_sel #(.PC_W(PC_W)) u_pc_sel (
        .icode   (icode_i),
        .cnd     (cnd_i),
        .valp    (valP_i),
        .valc    (valC_i),
        .valm    (valM_i),
        .next_pc (pc_sel)
    );

    // State, PC and status registers; run gates the first fetch until after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            stat  <= STAT_AOK;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            stat  <= stat_nxt;
            run   <= 1'b1;
        end
    end

    // Next-state, next-PC/status and per-state memory/stage outputs
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        stat_nxt     = stat;
        mem_req_o    = 1'b0;
        mem_ifetch_o = 1'b0;
        stage_en_o   = '0;
        case (state)
            S_FETCH: begin
                if (run) begin
                    mem_req_o    = 1'b1;
                    mem_ifetch_o = 1'b1;
                    if (mem_ack_i) begin
                        stage_en_o[STG_FETCH] = 1'b1;
                        if (mem_err_i) begin
                            stat_nxt  = STAT_ADR;
                            state_nxt = S_STOP;
                        end else begin
                            state_nxt = S_DECODE;
                        end
                    end
                end
            end
            S_DECODE: begin
                stage_en_o[STG_DEC] = 1'b1;
                if (icode_i > I_POPL) begin
                    stat_nxt  = STAT_INS;
                    state_nxt = S_STOP;
                end else if (icode_i == I_HALT) begin
                    stat_nxt  = STAT_HLT;
                    state_nxt = S_STOP;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                stage_en_o[STG_EX] = 1'b1;
                if (needs_mem(icode_i)) begin
                    state_nxt = S_MEMORY;
                end else if (needs_wb_only(icode_i)) begin
                    state_nxt = S_WRITEBACK;
                end else begin
                    state_nxt = S_PCUPDATE;
                end
            end
            S_MEMORY: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    stage_en_o[STG_MEM] = 1'b1;
                    if (mem_err_i) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = S_STOP;
                    end else if (icode_i == I_RMMOVL) begin
                        state_nxt = S_PCUPDATE;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                stage_en_o[STG_WB] = 1'b1;
                state_nxt          = S_PCUPDATE;
            end
            S_PCUPDATE: begin
                stage_en_o[STG_PCUPD] = 1'b1;
                pc_nxt                = pc_sel;
`ifdef Y86_SINGLE_STEP_EN
                state_nxt             = S_STEPWAIT;
`else
                state_nxt             = S_FETCH;
`endif
            end
`ifdef Y86_SINGLE_STEP_EN
            S_STEPWAIT: begin
                if (step_i) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            S_STOP: begin
                state_nxt = S_STOP;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign pc_o     = pc;
    assign stat_o   = stat;
    assign halted_o = (state == S_STOP);

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Table-driven bench for the Y86 SEQ stage sequencer.
module tb_y86_seq_ctrl;

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] RST_PC   = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] valp, valc, valm;
    logic        ack, err, step;
    logic        req, ifetch;
    logic [5:0]  en;
    logic [31:0] pc;
    logic [1:0]  stat;
    logic        halted;

    int checks = 0;
    int errors = 0;

    y86_seq_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .icode_i      (icode),
        .cnd_i        (cnd),
        .valP_i       (valp),
        .valC_i       (valc),
        .valM_i       (valm),
        .mem_ack_i    (ack),
        .mem_err_i    (err),
        .step_i       (step),
        .mem_req_o    (req),
        .mem_ifetch_o (ifetch),
        .stage_en_o   (en),
        .pc_o         (pc),
        .stat_o       (stat),
        .halted_o     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ack, err;
        logic [3:0]  icode;
        logic        cnd, step;
        logic [31:0] valp, valc, valm;
        logic        e_req, e_if;
        logic [5:0]  e_en;
        logic [31:0] e_pc;
        logic [1:0]  e_stat;
        logic        e_halt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic a, input logic e, input logic [3:0] ic,
                                input logic c, input logic s, input logic [31:0] vp,
                                input logic [31:0] vc, input logic [31:0] vm,
                                input logic xr, input logic xi, input logic [5:0] xe,
                                input logic [31:0] xp, input logic [1:0] xs, input logic xh);
        vec_t v;
        v.rst = r; v.ack = a; v.err = e; v.icode = ic; v.cnd = c; v.step = s;
        v.valp = vp; v.valc = vc; v.valm = vm;
        v.e_req = xr; v.e_if = xi; v.e_en = xe; v.e_pc = xp; v.e_stat = xs; v.e_halt = xh;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Short-hand for a row with no error and no step pulse
    task automatic add(input logic a, input logic [3:0] ic, input logic c, input logic [31:0] vp,
                       input logic [31:0] vc, input logic [31:0] vm, input logic xr, input logic xi,
                       input logic [5:0] xe, input logic [31:0] xp, input logic [1:0] xs, input logic xh);
        vq.push_back(mk(1'b0, a, 1'b0, ic, c, 1'b0, vp, vc, vm, xr, xi, xe, xp, xs, xh));
    endtask

    task automatic add_rst(input logic r, input logic [31:0] xp, input logic [1:0] xs, input logic xh);
        vq.push_back(mk(r, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, xp, xs, xh));
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; err = 1'b0; step = 1'b0; icode = 4'h1; cnd = 1'b0;
        valp = '0; valc = '0; valm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_pc",     -1, pc, RST_PC);
        check("reset_stat",   -1, 32'(stat), 32'd0);
        check("reset_halted", -1, 32'(halted), 32'd0);
        check("reset_req",    -1, 32'(req), 32'd0);
        check("reset_en",     -1, 32'(en), 32'd0);

`ifdef Y86_SINGLE_STEP_EN
        // Release cycle, then a nop that parks in STEPWAIT until step_i
        add(1'b0, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd0, 1'b0);
        add(1'b1, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h10, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b1, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h11, 2'd0, 1'b0);
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h11, 2'd0, 1'b0));
        add(1'b0, 4'h1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, 6'h00, 32'h11, 2'd0, 1'b0);
`else
        // Release cycle: stray ack and step are ignored
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 32'h16, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd0, 1'b0));
        // irmovl: F D E W P
        add(1'b1, 4'h3, 1'b0, 32'h16, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h3, 1'b0, 32'h16, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h3, 1'b0, 32'h16, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h3, 1'b0, 32'h16, 32'h0, 32'h0, 1'b0, 1'b0, 6'h10, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h3, 1'b0, 32'h16, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h10, 2'd0, 1'b0);
        // jXX not taken
        add(1'b1, 4'h7, 1'b0, 32'h1b, 32'h40, 32'h0, 1'b1, 1'b1, 6'h01, 32'h16, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b0, 32'h1b, 32'h40, 32'h0, 1'b0, 1'b0, 6'h02, 32'h16, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b0, 32'h1b, 32'h40, 32'h0, 1'b0, 1'b0, 6'h04, 32'h16, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b0, 32'h1b, 32'h40, 32'h0, 1'b0, 1'b0, 6'h20, 32'h16, 2'd0, 1'b0);
        // jXX taken
        add(1'b1, 4'h7, 1'b1, 32'h20, 32'h40, 32'h0, 1'b1, 1'b1, 6'h01, 32'h1b, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b1, 32'h20, 32'h40, 32'h0, 1'b0, 1'b0, 6'h02, 32'h1b, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b1, 32'h20, 32'h40, 32'h0, 1'b0, 1'b0, 6'h04, 32'h1b, 2'd0, 1'b0);
        add(1'b0, 4'h7, 1'b1, 32'h20, 32'h40, 32'h0, 1'b0, 1'b0, 6'h20, 32'h1b, 2'd0, 1'b0);
        // mrmovl with data ack delayed 5 cycles
        add(1'b1, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h40, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h40, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h40, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b1, 1'b0, 6'h00, 32'h40, 2'd0, 1'b0);
        add(1'b1, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b1, 1'b0, 6'h08, 32'h40, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b0, 1'b0, 6'h10, 32'h40, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h46, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h40, 2'd0, 1'b0);
        // ret with one fetch wait
        add(1'b0, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b1, 1'b1, 6'h00, 32'h46, 2'd0, 1'b0);
        add(1'b1, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b1, 1'b1, 6'h01, 32'h46, 2'd0, 1'b0);
        add(1'b0, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b0, 1'b0, 6'h02, 32'h46, 2'd0, 1'b0);
        add(1'b0, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b0, 1'b0, 6'h04, 32'h46, 2'd0, 1'b0);
        add(1'b1, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b1, 1'b0, 6'h08, 32'h46, 2'd0, 1'b0);
        add(1'b0, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b0, 1'b0, 6'h10, 32'h46, 2'd0, 1'b0);
        add(1'b0, 4'h9, 1'b0, 32'h47, 32'h0, 32'h88, 1'b0, 1'b0, 6'h20, 32'h46, 2'd0, 1'b0);
        // rmmovl: memory then straight to PC update
        add(1'b1, 4'h4, 1'b0, 32'h8e, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h88, 2'd0, 1'b0);
        add(1'b0, 4'h4, 1'b0, 32'h8e, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h88, 2'd0, 1'b0);
        add(1'b0, 4'h4, 1'b0, 32'h8e, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h88, 2'd0, 1'b0);
        add(1'b1, 4'h4, 1'b0, 32'h8e, 32'h0, 32'h0, 1'b1, 1'b0, 6'h08, 32'h88, 2'd0, 1'b0);
        add(1'b0, 4'h4, 1'b0, 32'h8e, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h88, 2'd0, 1'b0);
        // nop
        add(1'b1, 4'h1, 1'b0, 32'h8f, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h8e, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h8f, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h8e, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h8f, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h8e, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h8f, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h8e, 2'd0, 1'b0);
        // invalid icode C: INS, stop, acks ignored
        add(1'b1, 4'hC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h8f, 2'd0, 1'b0);
        add(1'b0, 4'hC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h8f, 2'd0, 1'b0);
        add(1'b1, 4'hC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h8f, 2'd3, 1'b1);
        add(1'b1, 4'hC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h8f, 2'd3, 1'b1);
        add_rst(1'b1, 32'h8f, 2'd3, 1'b1);
        add_rst(1'b0, 32'h10, 2'd0, 1'b0);
        // halt
        add(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd1, 1'b1);
        add_rst(1'b1, 32'h10, 2'd1, 1'b1);
        add_rst(1'b0, 32'h10, 2'd0, 1'b0);
        // fetch error
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0));
        add(1'b0, 4'h3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd2, 1'b1);
        add_rst(1'b1, 32'h10, 2'd2, 1'b1);
        add_rst(1'b0, 32'h10, 2'd0, 1'b0);
        // data error on mrmovl
        add(1'b1, 4'h5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h10, 2'd0, 1'b0);
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 6'h08, 32'h10, 2'd0, 1'b0));
        add(1'b0, 4'h5, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd2, 1'b1);
        add_rst(1'b1, 32'h10, 2'd2, 1'b1);
        add_rst(1'b0, 32'h10, 2'd0, 1'b0);
        // nop to move PC, then reset in the middle of a fetch wait
        add(1'b1, 4'h1, 1'b0, 32'h2a, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h2a, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h2a, 32'h0, 32'h0, 1'b0, 1'b0, 6'h04, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h2a, 32'h0, 32'h0, 1'b0, 1'b0, 6'h20, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h00, 32'h2a, 2'd0, 1'b0);
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h00, 32'h2a, 2'd0, 1'b0));
        add(1'b1, 4'h1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h00, 32'h10, 2'd0, 1'b0);
        add(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'h01, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h02, 32'h10, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h10, 2'd1, 1'b1);
`endif

        // Apply each row just after the falling edge and check before the rising edge
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; ack = vq[i].ack; err = vq[i].err; icode = vq[i].icode;
            cnd = vq[i].cnd; step = vq[i].step;
            valp = vq[i].valp; valc = vq[i].valc; valm = vq[i].valm;
            #1;
            check("mem_req",    i, 32'(req),    32'(vq[i].e_req));
            check("mem_ifetch", i, 32'(ifetch), 32'(vq[i].e_if));
            check("stage_en",   i, 32'(en),     32'(vq[i].e_en));
            check("pc",         i, pc,          vq[i].e_pc);
            check("stat",       i, 32'(stat),   32'(vq[i].e_stat));
            check("halted",     i, 32'(halted), 32'(vq[i].e_halt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
